flptmult_pipe_mult: RTL and testbench

//  Parametrised, pipelined successor to the 5-bit fixed-point mantissa multiplier in the FIR floating-point datapath.

---
 rtl/flptmult_pkg.sv | 45 ++++
 rtl/flptmult_pipe_mult_if.sv | 33 +++
 rtl/flptmult_csa_reduce.sv | 122 ++++++++++++
 rtl/flptmult_pipe_mult.sv | 138 +++++++++++++
 tb/tb_flptmult_pipe_mult.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flptmult_pkg.sv
// flptmult_pkg: constants and helper functions for the pipelined mantissa multiplier.
//   FLPT_MANT_W_DEFAULT  default mantissa operand width
//   FLPT_PIPE_MAX        deepest supported pipeline
//   prod_w()             product width for a given operand width
//   norm_bit()           normalise hint bit, shared with the downstream normaliser
//   dadda_height()       Dadda stage height targets, smallest first
//   fa() / ha()          full/half adder cells, result packed as {carry, sum}
package flptmult_pkg;

  localparam int FLPT_MANT_W_DEFAULT = 5;
  localparam int FLPT_PIPE_MAX       = 3;
  localparam int FLPT_DADDA_STEPS    = 8;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // top2 = {prod[MSB], prod[MSB-1]}
  function automatic logic norm_bit(input logic signed_mode, input logic [1:0] top2);
    return signed_mode ? (top2[1] ^ top2[0]) : top2[1];
  endfunction

  // Height sequence 2,3,4,6,9,13,19,28; covers trees up to 16-bit operands.
  function automatic int dadda_height(input int step);
    case (step)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      3:       return 6;
      4:       return 9;
      5:       return 13;
      6:       return 19;
      default: return 28;
    endcase
  endfunction

  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

endpackage

// File: rtl/flptmult_pipe_mult_if.sv
// flptmult_pipe_mult_if: operand/product valid-ready bundle.
//   in_valid/in_ready   operand handshake
//   in_a, in_b          operands (WIDTH bits)
//   in_signed           1: two's complement, 0: unsigned
//   out_valid/out_ready product handshake
//   out_prod            exact 2*WIDTH-bit product
//   out_norm            normalise hint bit
// master = producer/consumer side, slave = multiplier side.
interface flptmult_pipe_mult_if
  import flptmult_pkg::*;
#(
  parameter int WIDTH = FLPT_MANT_W_DEFAULT
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_prod;
  logic                 out_norm;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_prod, out_norm
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_prod, out_norm
  );
endinterface

// File: rtl/flptmult_csa_reduce.sv
// flptmult_csa_reduce: combinational partial-product generation and Dadda reduction.
//   a, b         WIDTH-bit operands
//   signed_mode  1: Baugh-Wooley two's-complement partial products, 0: plain AND array
//   sum_row      first carry-save row (2*WIDTH bits)
//   carry_row    second carry-save row, already aligned; product = sum_row + carry_row
module flptmult_csa_reduce
  import flptmult_pkg::*;
#(
  parameter int WIDTH = FLPT_MANT_W_DEFAULT
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] sum_row,
  output logic [2*WIDTH-1:0] carry_row
);
  localparam int PW = prod_w(WIDTH);
  // Tallest column is WIDTH bits; two spare slots give headroom.
  localparam int H  = WIDTH + 2;

  typedef logic [H-1:0] col_t;

  // Each column is a packed bit list; ht[] is how many entries are live.
  col_t       col [PW];
  col_t       nc  [PW];
  int         ht  [PW];
  int         nh  [PW];
  int         p;
  int         d;
  int         cn;
  logic       pp;
  logic [1:0] cs;
  col_t       t;

  always_comb begin
    for (int c = 0; c < PW; c++) begin
      col[c] = '0;
      nc[c]  = '0;
      ht[c]  = 0;
      nh[c]  = 0;
    end
    p  = 0;
    d  = 0;
    cn = 0;
    pp = 1'b0;
    cs = 2'b00;
    t  = '0;

    // Baugh-Wooley: cross terms touching exactly one sign bit are inverted.
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp = a[j] & b[i];
        if (signed_mode && ((i == WIDTH - 1) != (j == WIDTH - 1)))
          pp = ~pp;
        col[i+j] = col[i+j] | (col_t'(pp) << ht[i+j]);
        ht[i+j]  = ht[i+j] + 1;
      end
    end
    if (signed_mode) begin
      col[WIDTH]  = col[WIDTH] | (col_t'(1'b1) << ht[WIDTH]);
      ht[WIDTH]   = ht[WIDTH] + 1;
      col[PW-1]   = col[PW-1] | (col_t'(1'b1) << ht[PW-1]);
      ht[PW-1]    = ht[PW-1] + 1;
    end

    // Dadda stages, largest target first. Carries into column c+1 are
    // placed before that column is processed, so its count includes them.
    for (int s = FLPT_DADDA_STEPS - 1; s >= 0; s--) begin
      d = dadda_height(s);
      if (d < H) begin
        for (int c = 0; c < PW; c++) begin
          nc[c] = '0;
          nh[c] = 0;
        end
        for (int c = 0; c < PW; c++) begin
          p  = 0;
          cn = (c < PW - 1) ? c + 1 : c;
          for (int k = 0; k < H; k++) begin
            if (ht[c] - p + nh[c] > d) begin
              t = col[c] >> p;
              if ((ht[c] - p + nh[c] - d >= 2) && (ht[c] - p >= 3)) begin
                cs = fa(t[0], t[1], t[2]);
                p  = p + 3;
              end else if (ht[c] - p >= 2) begin
                cs = ha(t[0], t[1]);
                p  = p + 2;
              end else begin
                cs = 2'b00;
              end
              if (p > 0) begin
                nc[c] = nc[c] | (col_t'(cs[0]) << nh[c]);
                nh[c] = nh[c] + 1;
                // Carry out of the top column is dropped: result is mod 2^(2W).
                if (c < PW - 1) begin
                  nc[cn] = nc[cn] | (col_t'(cs[1]) << nh[cn]);
                  nh[cn] = nh[cn] + 1;
                end
              end
            end
          end
          for (int k = 0; k < H; k++) begin
            if (k >= p && k < ht[c]) begin
              t     = col[c] >> k;
              nc[c] = nc[c] | (col_t'(t[0]) << nh[c]);
              nh[c] = nh[c] + 1;
            end
          end
        end
        for (int c = 0; c < PW; c++) begin
          col[c] = nc[c];
          ht[c]  = nh[c];
        end
      end
    end

    for (int c = 0; c < PW; c++) begin
      sum_row[c]   = col[c][0];
      carry_row[c] = col[c][1];
    end
  end

endmodule

// File: rtl/flptmult_pipe_mult.sv
// flptmult_pipe_mult: pipelined WIDTH x WIDTH multiplier, unsigned or signed per transaction.
//   clk   rising-edge clock
//   rst   synchronous active-high reset; clears all stage valids and the output register
//   bus   slave side of flptmult_pipe_mult_if (operand in, product out, valid/ready both ways)
// Register placement, counted back from the output register:
//   STAGES=1: tree + adder -> output register
//   STAGES=2: tree -> CSA register -> adder -> output register
//   STAGES=3: operand register -> tree -> CSA register -> adder -> output register
module flptmult_pipe_mult
  import flptmult_pkg::*;
#(
  parameter int WIDTH  = FLPT_MANT_W_DEFAULT,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  flptmult_pipe_mult_if.slave bus
);
  localparam int PW = prod_w(WIDTH);

  logic             tree_v;
  logic             tree_s;
  logic             tree_ready;
  logic [WIDTH-1:0] tree_a;
  logic [WIDTH-1:0] tree_b;
  logic [PW-1:0]    tree_sum;
  logic [PW-1:0]    tree_carry;

  logic             add_v;
  logic             add_s;
  logic             add_ready;
  logic [PW-1:0]    add_sum;
  logic [PW-1:0]    add_carry;
  logic [PW-1:0]    add_prod;

  logic             out_v;
  logic [PW-1:0]    out_prod_q;
  logic             out_norm_q;

  assign add_ready = ~out_v | bus.out_ready;

  if (STAGES >= 3) begin : g_op
    logic             op_v;
    logic             op_s;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    assign bus.in_ready = ~op_v | tree_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        op_v <= 1'b0;
      end else if (bus.in_ready) begin
        op_v <= bus.in_valid;
        if (bus.in_valid) begin
          op_a <= bus.in_a;
          op_b <= bus.in_b;
          op_s <= bus.in_signed;
        end
      end
    end

    assign tree_v = op_v;
    assign tree_a = op_a;
    assign tree_b = op_b;
    assign tree_s = op_s;
  end else begin : g_no_op
    assign bus.in_ready = tree_ready;
    assign tree_v       = bus.in_valid;
    assign tree_a       = bus.in_a;
    assign tree_b       = bus.in_b;
    assign tree_s       = bus.in_signed;
  end

  flptmult_csa_reduce #(.WIDTH(WIDTH)) u_csa (
    .a           (tree_a),
    .b           (tree_b),
    .signed_mode (tree_s),
    .sum_row     (tree_sum),
    .carry_row   (tree_carry)
  );

  if (STAGES >= 2) begin : g_csa
    logic          csa_v;
    logic          csa_s;
    logic [PW-1:0] csa_sum;
    logic [PW-1:0] csa_carry;

    assign tree_ready = ~csa_v | add_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        csa_v <= 1'b0;
      end else if (tree_ready) begin
        csa_v <= tree_v;
        if (tree_v) begin
          csa_sum   <= tree_sum;
          csa_carry <= tree_carry;
          csa_s     <= tree_s;
        end
      end
    end

    assign add_v     = csa_v;
    assign add_s     = csa_s;
    assign add_sum   = csa_sum;
    assign add_carry = csa_carry;
  end else begin : g_no_csa
    assign tree_ready = add_ready;
    assign add_v      = tree_v;
    assign add_s      = tree_s;
    assign add_sum    = tree_sum;
    assign add_carry  = tree_carry;
  end

  assign add_prod = add_sum + add_carry;

  // Data only loads with a valid entry so a stalled or empty stage never
  // disturbs the held product.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v      <= 1'b0;
      out_prod_q <= '0;
      out_norm_q <= 1'b0;
    end else if (add_ready) begin
      out_v <= add_v;
      if (add_v) begin
        out_prod_q <= add_prod;
        out_norm_q <= norm_bit(add_s, add_prod[PW-1 -: 2]);
      end
    end
  end

  assign bus.out_valid = out_v;
  assign bus.out_prod  = out_prod_q;
  assign bus.out_norm  = out_norm_q;

endmodule

// File: tb/tb_flptmult_pipe_mult.sv
// tb_flptmult_pipe_mult: WIDTH=5 multiplier at STAGES=1,2,3 (instances 0,1,2).
// Directed scenarios run on the STAGES=2 instance; the exhaustive sweep covers all three.
module tb_flptmult_pipe_mult;
  localparam int W  = 5;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          v_d      [3];
  logic [W-1:0]  a_d      [3];
  logic [W-1:0]  b_d      [3];
  logic          s_d      [3];
  logic          ordy_d   [3];
  logic          iready_w [3];
  logic          ovalid_w [3];
  logic          onorm_w  [3];
  logic [PW-1:0] oprod_w  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    flptmult_pipe_mult_if #(.WIDTH(W)) bus ();
    assign bus.in_valid  = v_d[k];
    assign bus.in_a      = a_d[k];
    assign bus.in_b      = b_d[k];
    assign bus.in_signed = s_d[k];
    assign bus.out_ready = ordy_d[k];
    assign iready_w[k]   = bus.in_ready;
    assign ovalid_w[k]   = bus.out_valid;
    assign oprod_w[k]    = bus.out_prod;
    assign onorm_w[k]    = bus.out_norm;

    flptmult_pipe_mult #(.WIDTH(W), .STAGES(k + 1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  // Reference: exact product by integer arithmetic, returned as {norm, prod}.
  function automatic logic [PW:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sm);
    int            p;
    logic [PW-1:0] pr;
    if (sm) p = $signed(a) * $signed(b);
    else    p = int'(a) * int'(b);
    pr = p[PW-1:0];
    return {(sm ? (pr[PW-1] ^ pr[PW-2]) : pr[PW-1]), pr};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      v_d[k]    = 1'b0;
      a_d[k]    = '0;
      b_d[k]    = '0;
      s_d[k]    = 1'b0;
      ordy_d[k] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    repeat (3) cyc();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ovalid_w[k] !== 1'b0 || oprod_w[k] !== '0 || onorm_w[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got valid=%b prod=%h norm=%b expected 0/000/0",
                 k, ovalid_w[k], oprod_w[k], onorm_w[k]);
      end
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (iready_w[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, iready_w[k]);
      end
    end
  endtask

  task automatic test_unsigned_basic();
    cyc();
    v_d[1] = 1'b1; a_d[1] = 5'd31; b_d[1] = 5'd31; s_d[1] = 1'b0; ordy_d[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (iready_w[1] !== 1'b1) begin
      errors++;
      $display("FAIL basic_in_ready: got %b expected 1", iready_w[1]);
    end
    cyc();
    v_d[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (ovalid_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early: got valid=%b expected 0", ovalid_w[1]);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (ovalid_w[1] !== 1'b1 || oprod_w[1] !== 10'h3C1 || onorm_w[1] !== 1'b1) begin
      errors++;
      $display("FAIL basic_31x31: got valid=%b prod=%h norm=%b expected 1/3c1/1",
               ovalid_w[1], oprod_w[1], onorm_w[1]);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (ovalid_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_duplicate: got valid=%b expected 0", ovalid_w[1]);
    end
  endtask

  task automatic test_signed_mixed();
    logic [W-1:0]  ta [7];
    logic [W-1:0]  tb_ [7];
    logic          ts [7];
    logic [PW-1:0] tp [7];
    logic          tn [7];
    ta  = '{5'h10, 5'h10, 5'h00, 5'h1F, 5'h1F, 5'h10, 5'h10};
    tb_ = '{5'h10, 5'h0F, 5'h1F, 5'h1F, 5'h1F, 5'h01, 5'h01};
    ts  = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    tp  = '{10'h100, 10'h310, 10'h000, 10'h3C1, 10'h001, 10'h010, 10'h3F0};
    tn  = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
    for (int t = 0; t < 9; t++) begin
      cyc();
      ordy_d[1] = 1'b1;
      if (t < 7) begin
        v_d[1] = 1'b1; a_d[1] = ta[t]; b_d[1] = tb_[t]; s_d[1] = ts[t];
      end else begin
        v_d[1] = 1'b0;
      end
      @(negedge clk);
      if (t >= 2) begin
        checks++;
        if (ovalid_w[1] !== 1'b1 || oprod_w[1] !== tp[t-2] || onorm_w[1] !== tn[t-2]) begin
          errors++;
          $display("FAIL mixed[%0d]: got valid=%b prod=%h norm=%b expected 1/%h/%b",
                   t - 2, ovalid_w[1], oprod_w[1], onorm_w[1], tp[t-2], tn[t-2]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [PW:0]   q[$];
    int            sent = 0;
    int            got = 0;
    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_prod = '0;
    logic          exp_rdy;
    for (int c = 0; c < 40 && got < 6; c++) begin
      cyc();
      v_d[1]    = (sent < 6);
      a_d[1]    = 5'(sent + 1);
      b_d[1]    = 5'd3;
      s_d[1]    = 1'b0;
      ordy_d[1] = (c >= 4);
      @(negedge clk);
      exp_rdy = ordy_d[1] || ((sent - got) < 2);
      checks++;
      if (iready_w[1] !== exp_rdy) begin
        errors++;
        $display("FAIL bp_in_ready cycle %0d: got %b expected %b", c, iready_w[1], exp_rdy);
      end
      if (prev_stall) begin
        checks++;
        if (ovalid_w[1] !== 1'b1 || oprod_w[1] !== prev_prod) begin
          errors++;
          $display("FAIL bp_hold cycle %0d: got valid=%b prod=%h expected 1/%h",
                   c, ovalid_w[1], oprod_w[1], prev_prod);
        end
      end
      if (ovalid_w[1] === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_spurious cycle %0d: got prod=%h expected no output", c, oprod_w[1]);
        end else if ({onorm_w[1], oprod_w[1]} !== q[0]) begin
          errors++;
          $display("FAIL bp_data cycle %0d: got %h expected %h", c,
                   {onorm_w[1], oprod_w[1]}, q[0]);
        end
      end
      if (ovalid_w[1] === 1'b1 && ordy_d[1] && q.size() > 0) begin
        void'(q.pop_front());
        got++;
      end
      if (v_d[1] && iready_w[1] === 1'b1) begin
        q.push_back(ref_mul(a_d[1], b_d[1], 1'b0));
        sent++;
      end
      prev_stall = (ovalid_w[1] === 1'b1) && !ordy_d[1];
      prev_prod  = oprod_w[1];
    end
    v_d[1] = 1'b0;
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL bp_drain: got %0d products expected 6", got);
    end
  endtask

  task automatic test_full_throughput();
    logic [PW:0] exp_a [64];
    for (int t = 0; t < 66; t++) begin
      cyc();
      ordy_d[1] = 1'b1;
      if (t < 64) begin
        v_d[1] = 1'b1;
        a_d[1] = 5'($urandom);
        b_d[1] = 5'($urandom);
        s_d[1] = 1'($urandom);
        exp_a[t] = ref_mul(a_d[1], b_d[1], s_d[1]);
      end else begin
        v_d[1] = 1'b0;
      end
      @(negedge clk);
      if (t < 64) begin
        checks++;
        if (iready_w[1] !== 1'b1) begin
          errors++;
          $display("FAIL tput_in_ready[%0d]: got %b expected 1", t, iready_w[1]);
        end
      end
      if (t < 2) begin
        checks++;
        if (ovalid_w[1] !== 1'b0) begin
          errors++;
          $display("FAIL tput_fill[%0d]: got valid=%b expected 0", t, ovalid_w[1]);
        end
      end else begin
        checks++;
        if (ovalid_w[1] !== 1'b1 || {onorm_w[1], oprod_w[1]} !== exp_a[t-2]) begin
          errors++;
          $display("FAIL tput[%0d]: got valid=%b data=%h expected 1/%h",
                   t - 2, ovalid_w[1], {onorm_w[1], oprod_w[1]}, exp_a[t-2]);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    cyc();
    v_d[1] = 1'b1; a_d[1] = 5'd7; b_d[1] = 5'd9; s_d[1] = 1'b0; ordy_d[1] = 1'b0;
    cyc();
    a_d[1] = 5'd3; b_d[1] = 5'd5;
    cyc();
    v_d[1] = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    checks++;
    if (ovalid_w[1] !== 1'b1 || oprod_w[1] !== 10'd63) begin
      errors++;
      $display("FAIL midop_inflight: got valid=%b prod=%h expected 1/03f", ovalid_w[1], oprod_w[1]);
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ovalid_w[1] !== 1'b0 || iready_w[1] !== 1'b1) begin
      errors++;
      $display("FAIL midop_after_reset: got valid=%b in_ready=%b expected 0/1",
               ovalid_w[1], iready_w[1]);
    end
    ordy_d[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (ovalid_w[1] !== 1'b0) begin
        errors++;
        $display("FAIL midop_ghost[%0d]: got valid=%b prod=%h expected 0", c, ovalid_w[1], oprod_w[1]);
      end
    end
  endtask

  task automatic test_exhaustive();
    for (int k = 0; k < 3; k++) begin
      for (int m = 0; m < 2; m++) begin
        logic [PW:0] q[$];
        int          i = 0;
        q.delete();
        for (int c = 0; c < 5000 && !(i == 1024 && q.size() == 0); c++) begin
          cyc();
          v_d[k]    = (i < 1024);
          a_d[k]    = 5'(i);
          b_d[k]    = 5'(i >> 5);
          s_d[k]    = 1'(m);
          ordy_d[k] = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (ovalid_w[k] === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL exh_spurious S=%0d m=%0d: got %h expected no output",
                       k + 1, m, oprod_w[k]);
            end else if ({onorm_w[k], oprod_w[k]} !== q[0]) begin
              errors++;
              $display("FAIL exh S=%0d m=%0d: got %h expected %h", k + 1, m,
                       {onorm_w[k], oprod_w[k]}, q[0]);
            end
            if (ordy_d[k] && q.size() > 0) void'(q.pop_front());
          end
          if (v_d[k] && iready_w[k] === 1'b1) begin
            q.push_back(ref_mul(a_d[k], b_d[k], s_d[k]));
            i++;
          end
        end
        v_d[k]    = 1'b0;
        ordy_d[k] = 1'b1;
        checks++;
        if (i != 1024 || q.size() != 0) begin
          errors++;
          $display("FAIL exh_drain S=%0d m=%0d: got sent=%0d pending=%0d expected 1024/0",
                   k + 1, m, i, q.size());
        end
      end
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_unsigned_basic();
    test_signed_mixed();
    test_backpressure();
    test_full_throughput();
    test_reset_midop();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
